// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external-memory bus responder.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // True when a byte offset from the base address falls inside the array window.
  function automatic logic offset_in_window(input logic [31:0] offset,
                                            input logic [32:0] span);
    return ({1'b0, offset} < span);
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port synchronous word RAM; the read register holds zero unless a read is issued.
module ext_mem_array #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 1024,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem_r [DEPTH];
  logic [WORD_SIZE-1:0] rdata_r;

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: loads the addressed word on a read, otherwise returns to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= '0;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/ext_mem_responder.sv
// Bus target: latches a read/write request, waits LATENCY cycles, then acks for one
// cycle with read data, backed by an internal word array.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter int          WORD_SIZE = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          mem_addr,
  input  logic                 en_ext_mem_re,
  input  logic                 en_ext_mem_wr,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 mem_ready
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] SPAN       = 33'(DEPTH) * 33'(WORD_BYTES);
  localparam bit          DIRECT_ACK = (LATENCY == 1);
  // BUSY lasts LATENCY-1 cycles; the counter reaching zero marks the last one.
  localparam logic [3:0]  CNT_LOAD   = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [3:0]           cnt_r;
  logic [3:0]           cnt_nxt_s;
  logic [31:0]          addr_r;
  logic [WORD_SIZE-1:0] data_r;
  logic                 wr_r;
  logic                 mem_ready_r;

  logic                 req_s;
  logic                 latch_s;
  logic                 enter_ack_s;
  logic [31:0]          acc_addr_s;
  logic [WORD_SIZE-1:0] acc_data_s;
  logic                 acc_wr_s;
  logic [31:0]          offset_s;
  logic                 in_range_s;
  logic                 ram_we_s;
  logic                 ram_re_s;
  logic [AW-1:0]        ram_addr_s;

  assign req_s = en_ext_mem_re | en_ext_mem_wr;

  // State and latency-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; an abort in BUSY takes priority over the count reaching zero.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    enter_ack_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          latch_s   = 1'b1;
          cnt_nxt_s = CNT_LOAD;
          if (DIRECT_ACK) begin
            state_nxt_s = ACK;
            enter_ack_s = 1'b1;
          end else begin
            state_nxt_s = BUSY;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (!req_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r == 4'd0) begin
          state_nxt_s = ACK;
          enter_ack_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Request latches: address, write data and operation captured at the sample edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= 32'h0000_0000;
      data_r <= '0;
      wr_r   <= 1'b0;
    end else if (latch_s) begin
      addr_r <= mem_addr;
      data_r <= data_in;
      wr_r   <= en_ext_mem_wr;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
      wr_r   <= wr_r;
    end
  end

  // With LATENCY=1 the access happens on the sample edge, before the latches are loaded.
  always_comb begin
    if (state_r == IDLE) begin
      acc_addr_s = mem_addr;
      acc_data_s = data_in;
      acc_wr_s   = en_ext_mem_wr;
    end else begin
      acc_addr_s = addr_r;
      acc_data_s = data_r;
      acc_wr_s   = wr_r;
    end
  end

  assign offset_s   = acc_addr_s - BASE_ADDR;
  assign in_range_s = offset_in_window(offset_s, SPAN);
  assign ram_addr_s = offset_s[AW+1:2];
  assign ram_we_s   = enter_ack_s & acc_wr_s & in_range_s;
  assign ram_re_s   = enter_ack_s & ~acc_wr_s & in_range_s;

  // Acknowledge register, high only during the ACK state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready_r <= 1'b0;
    end else begin
      mem_ready_r <= enter_ack_s;
    end
  end

  ext_mem_array #(
    .WORD_SIZE (WORD_SIZE),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (ram_addr_s),
    .wdata (acc_data_s),
    .rdata (data_out)
  );

  assign mem_ready = mem_ready_r;

endmodule
